// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and integer duty cycle of an
// asynchronous PWM input. One valid pulse per completed period; a missing
// rising edge for TIMEOUT cycles reports stuck-high or stuck-low.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty_pct,
    output logic             valid,
    output logic             stuck_high,
    output logic             stuck_low,
    output logic             overrun
);

    // Dividend h*100 needs 7 extra bits on top of the counter width.
    localparam int DW = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DIVIDE  = 2'd2
    } state_t;

    logic             sync1_q, sync2_q, sync3_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hacc_q, hacc_d;
    logic [CNT_W-1:0] p_hold_q, p_hold_d;
    logic [CNT_W-1:0] h_hold_q, h_hold_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [6:0]       quo_q, quo_d;
    logic [2:0]       bit_q, bit_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [6:0]       duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             sh_q, sh_d;
    logic             sl_q, sl_d;
    logic             ovr_q, ovr_d;

    logic             rise;
    logic             timeout_hit;
    logic [DW-1:0]    trial;
    logic             ge;
    logic [6:0]       quo_next;

    // sync2_q is the synchronised input, sync3_q its one-cycle-old copy.
    assign rise        = sync2_q & ~sync3_q;
    // Fires on the cycle cnt steps onto TIMEOUT, so it happens only once per hold.
    assign timeout_hit = ~rise && (cnt_q == CNT_PRE);
    // Restoring division: trial subtract of the divisor shifted to the current quotient bit.
    assign trial       = DW'(p_hold_q) << bit_q;
    assign ge          = (rem_q >= trial);
    assign quo_next    = {quo_q[5:0], ge};

    // Next-state logic for counters, FSM, divider and registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hacc_d   = hacc_q;
        p_hold_d = p_hold_q;
        h_hold_d = h_hold_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        bit_d    = bit_q;
        period_d = period_q;
        high_d   = high_q;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        sh_d     = sh_q;
        sl_d     = sl_q;
        ovr_d    = 1'b0;

        // Both counters restart on every rise, including one that overruns.
        if (rise) begin
            cnt_d  = CNT_W'(1);
            hacc_d = CNT_W'(1);
            sh_d   = 1'b0;
            sl_d   = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sync2_q) begin
                hacc_d = hacc_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_MEASURE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    if (state_q == ST_MEASURE) begin
                        p_hold_d = cnt_q;
                        h_hold_d = hacc_q;
                        rem_d    = DW'(hacc_q) * DW'(100);
                        quo_d    = 7'd0;
                        bit_d    = 3'd6;
                        state_d  = ST_DIVIDE;
                    end
                end else if (timeout_hit) begin
                    sh_d     = sync2_q;
                    sl_d     = ~sync2_q;
                    period_d = '0;
                    high_d   = '0;
                    duty_d   = sync2_q ? 7'd100 : 7'd0;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                // A period ending here is dropped; the counters already restarted above.
                ovr_d = rise;
                if (ge) begin
                    rem_d = rem_q - trial;
                end
                quo_d = quo_next;
                if (bit_q == 3'd0) begin
                    period_d = p_hold_q;
                    high_d   = h_hold_q;
                    duty_d   = quo_next;
                    valid_d  = 1'b1;
                    state_d  = ST_MEASURE;
                end else begin
                    bit_d = bit_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state registers, including the input synchroniser, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hacc_q   <= '0;
            p_hold_q <= '0;
            h_hold_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            bit_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            sh_q     <= 1'b0;
            sl_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= pwm_in;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hacc_q   <= hacc_d;
            p_hold_q <= p_hold_d;
            h_hold_q <= h_hold_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            bit_q    <= bit_d;
            period_q <= period_d;
            high_q   <= high_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            sh_q     <= sh_d;
            sl_q     <= sl_d;
            ovr_q    <= ovr_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign duty_pct   = duty_q;
    assign valid      = valid_q;
    assign stuck_high = sh_q;
    assign stuck_low  = sl_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: table-driven duty vectors, randomized periods
// checked against an edge-timing reference model, and hand-written sequences
// for stuck detection, overrun, reset mid-divide and asynchronous edges.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TO      = 6000;
    localparam int ASYNC_P = 100;
    localparam int ASYNC_H = 40;
    localparam int ASYNC_N = 40;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [CNT_W-1:0] period, high_time;
    logic [6:0]       duty_pct;
    logic             valid, stuck_high, stuck_low, overrun;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .duty_pct   (duty_pct),
        .valid      (valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low),
        .overrun    (overrun)
    );

    // Counters and checking helpers
    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void chk_range(input string name, input longint act, input longint lo, input longint hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    endfunction

    // Reference model: works on the cycles at which rising edges are driven.
    // Synchroniser + edge detect adds 2 cycles, the divider 8 more.
    typedef struct {
        int cyc;
        int period;
        int high;
        int duty;
        bit sh;
        bit sl;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    bit   model_en = 1'b1;
    bit   armed;
    int   last_rise;
    int   last_high;
    int   last_cap;

    function automatic void model_clear();
        exp_q.delete();
        ovr_q.delete();
        armed     = 1'b0;
        last_rise = 0;
        last_high = 0;
        last_cap  = -100;
    endfunction

    function automatic void model_rise(input int t, input int h);
        exp_t e;
        int   p;
        if (!armed) begin
            armed = 1'b1;
        end else if (t - last_cap <= 7) begin
            // The previous capture is still being divided: this period is lost.
            ovr_q.push_back(t + 3);
        end else begin
            p        = t - last_rise;
            e.cyc    = t + 10;
            e.period = p;
            e.high   = last_high;
            e.duty   = (last_high * 100) / p;
            e.sh     = 1'b0;
            e.sl     = 1'b0;
            exp_q.push_back(e);
            last_cap = t;
        end
        last_rise = t;
        last_high = h;
    endfunction

    function automatic void model_timeout(input bit lvl);
        exp_t e;
        e.cyc    = last_rise + 2 + TO;
        e.period = 0;
        e.high   = 0;
        e.duty   = lvl ? 100 : 0;
        e.sh     = lvl;
        e.sl     = !lvl;
        exp_q.push_back(e);
        armed    = 1'b0;
        last_cap = -100;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    int n_async_valid = 0;
    int n_ovr_seen    = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (valid) begin
                if (!model_en) begin
                    n_async_valid++;
                    chk_range("async_period", period, ASYNC_P - 1, ASYNC_P + 1);
                    chk_range("async_high", high_time, ASYNC_H - 1, ASYNC_H + 1);
                end else if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("period", period, e.period);
                    chk("high_time", high_time, e.high);
                    chk("duty_pct", duty_pct, e.duty);
                    chk("stuck_flags", {stuck_high, stuck_low}, {e.sh, e.sl});
                end
            end
            if (overrun) begin
                n_ovr_seen++;
                if (model_en) begin
                    if (ovr_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_overrun: overrun=1 at cycle %0d, expected 0", cyc);
                    end else begin
                        chk("overrun_cycle", cyc, ovr_q.pop_front());
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        pwm_in = 1'b0;
        model_clear();
        model_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rise_drive(input int h);
        @(posedge clk);
        #1;
        pwm_in = 1'b1;
        if (model_en) model_rise(cyc, h);
    endtask

    // One aligned PWM period: high for h cycles, low for p-h cycles.
    task automatic run_period(input int p, input int h);
        rise_drive(h);
        repeat (h) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (p - h - 1) @(posedge clk);
    endtask

    task automatic drain_check(input string tag);
        repeat (15) @(posedge clk);
        chk({tag, "_pending_valid"}, exp_q.size(), 0);
        chk({tag, "_pending_overrun"}, ovr_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high_time"}, high_time, 0);
        chk({tag, "_duty"}, duty_pct, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_stuck_high"}, stuck_high, 0);
        chk({tag, "_stuck_low"}, stuck_low, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Duty-cycle vector table
    typedef struct {
        int p;
        int h;
        int e_period;
        int e_high;
        int e_duty;
    } vec_t;

    vec_t vecs[8];

    // Watchdog
    initial begin
        #2500000;
        n_total++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Test sequence
    initial begin
        int ovr_base;
        int p, h, off;

        vecs[0] = '{5000, 2500, 5000, 2500, 50};
        vecs[1] = '{3000, 1000, 3000, 1000, 33};
        vecs[2] = '{200,  199,  200,  199,  99};
        vecs[3] = '{100,  1,    100,  1,    1};
        vecs[4] = '{8,    4,    8,    4,    50};
        vecs[5] = '{9,    8,    9,    8,    88};
        vecs[6] = '{1000, 999,  1000, 999,  99};
        vecs[7] = '{16,   1,    16,   1,    6};

        // Reset values
        do_reset();
        @(negedge clk);
        check_all_zero("reset");

        // Table-driven nominal and rounding vectors
        for (int i = 0; i < 8; i++) begin
            do_reset();
            repeat (3) run_period(vecs[i].p, vecs[i].h);
            repeat (12) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_period", i), period, vecs[i].e_period);
            chk($sformatf("vec%0d_high", i), high_time, vecs[i].e_high);
            chk($sformatf("vec%0d_duty", i), duty_pct, vecs[i].e_duty);
            drain_check($sformatf("vec%0d", i));
        end

        // Randomized periods, including short ones that overrun
        do_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) p = $urandom_range(4, 10);
            else p = $urandom_range(11, 300);
            h = $urandom_range(1, p - 1);
            run_period(p, h);
        end
        drain_check("random");

        // Overrun: period 6, then back to period 8
        do_reset();
        ovr_base = n_ovr_seen;
        repeat (6) run_period(6, 3);
        repeat (4) run_period(8, 4);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("overrun_seen", (n_ovr_seen - ovr_base) > 0, 1);
        chk("after_overrun_duty", duty_pct, 50);
        chk("after_overrun_period", period, 8);
        drain_check("overrun");

        // Stuck high
        do_reset();
        repeat (3) run_period(100, 50);
        rise_drive(50);
        model_timeout(1'b1);
        repeat (TO + 20) @(posedge clk);
        @(negedge clk);
        chk("stuck_high_level", stuck_high, 1);
        chk("stuck_high_low_flag", stuck_low, 0);
        #1 pwm_in = 1'b0;
        repeat (50) @(posedge clk);
        fork
            run_period(100, 50);
            begin
                @(posedge clk);
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stuck_high_before_rise", stuck_high, 1);
                @(posedge clk);
                @(negedge clk);
                chk("stuck_high_cleared", stuck_high, 0);
            end
        join
        repeat (2) run_period(100, 50);
        drain_check("stuck_high");

        // Stuck low
        do_reset();
        repeat (3) run_period(100, 50);
        model_timeout(1'b0);
        repeat (TO + 20) @(posedge clk);
        @(negedge clk);
        chk("stuck_low_level", stuck_low, 1);
        chk("stuck_low_high_flag", stuck_high, 0);
        fork
            run_period(100, 50);
            begin
                @(posedge clk);
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stuck_low_before_rise", stuck_low, 1);
                @(posedge clk);
                @(negedge clk);
                chk("stuck_low_cleared", stuck_low, 0);
            end
        join
        repeat (2) run_period(100, 50);
        drain_check("stuck_low");

        // Reset during DIVIDE
        do_reset();
        repeat (3) run_period(40, 2);
        rise_drive(2);
        repeat (2) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        repeat (20) @(posedge clk);
        repeat (2) run_period(40, 2);
        drain_check("rst_mid");

        // Asynchronous edges with random sub-cycle phase
        do_reset();
        model_en      = 1'b0;
        n_async_valid = 0;
        ovr_base      = n_ovr_seen;
        @(posedge clk);
        for (int i = 0; i < ASYNC_N; i++) begin
            off = $urandom_range(1, 19);
            #(off) pwm_in = 1'b1;
            #(ASYNC_H * 20) pwm_in = 1'b0;
            #(ASYNC_P * 20 - ASYNC_H * 20 - off);
        end
        repeat (20) @(posedge clk);
        chk("async_valid_count", n_async_valid, ASYNC_N - 1);
        chk("async_overrun_count", n_ovr_seen - ovr_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
